// File: rtl/fsm_arbiter.sv
// Two-requester arbiter that shares one J/K flip-flop FSM, with grants capped at HOLD cycles.
// Define ROUND_ROBIN_EN to alternate winners on ties; without it, requester 0 always wins ties.
module fsm_arbiter #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic j0,
    input  logic k0,
    input  logic j1,
    input  logic k1,
    input  logic fsm_out,
    output logic gnt0,
    output logic gnt1,
    output logic fsm_j,
    output logic fsm_k,
    output logic done0,
    output logic done1,
    output logic rsp_out
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [2:0] LOAD    = 3'(HOLD - 1);

    logic [1:0] state_reg, state_next;
    logic [2:0] cnt_reg, cnt_next;
    logic       winner_reg, winner_next;
    logic       rsp_reg;
    logic       pick;
    logic       win_req;

    logic [1:0] req_v, j_v, k_v, gnt_v, done_v;

    assign req_v = {req1, req0};
    assign j_v   = {j1, j0};
    assign k_v   = {k1, k0};

`ifdef ROUND_ROBIN_EN
    logic last_reg;

    // On a tie the requester that did not win last time goes first.
    assign pick = (req0 && req1) ? ~last_reg : ~req0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_reg <= 1'b1;
        end else if (state_reg == RELEASE) begin
            last_reg <= winner_reg;
        end
    end
`else
    assign pick = ~req0;
`endif

    assign win_req = req_v[winner_reg];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        winner_next = winner_reg;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    state_next  = GRANT;
                    cnt_next    = LOAD;
                    winner_next = pick;
                end
            end
            GRANT: begin
                // The current cycle is always granted; the exit takes effect on the next edge.
                if (cnt_reg == 3'd0 || !win_req) begin
                    state_next = RELEASE;
                end else begin
                    cnt_next = cnt_reg - 3'd1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 3'd0;
            winner_reg <= 1'b0;
            rsp_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            winner_reg <= winner_next;
            if (state_reg == GRANT && state_next == RELEASE) begin
                rsp_reg <= fsm_out;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign gnt_v[gi]  = (state_reg == GRANT)   && (winner_reg == 1'(gi));
            assign done_v[gi] = (state_reg == RELEASE) && (winner_reg == 1'(gi));
        end
    endgenerate

    assign gnt0    = gnt_v[0];
    assign gnt1    = gnt_v[1];
    assign done0   = done_v[0];
    assign done1   = done_v[1];
    assign fsm_j   = (state_reg == GRANT) && j_v[winner_reg];
    assign fsm_k   = (state_reg == GRANT) && k_v[winner_reg];
    assign rsp_out = rsp_reg;

endmodule

// File: tb/tb_fsm_arbiter.sv
// Directed bench for fsm_arbiter: a HOLD=4 instance for the main sequences and a HOLD=1 instance.
module tb_fsm_arbiter;

    logic clk = 1'b0;
    logic reset;
    logic req0, req1, j0, k0, j1, k1, fsm_out;
    logic gnt0, gnt1, fsm_j, fsm_k, done0, done1, rsp_out;
    logic b_req0, b_req1, b_j0, b_k0, b_j1, b_k1, b_fsm_out;
    logic b_gnt0, b_gnt1, b_fsm_j, b_fsm_k, b_done0, b_done1, b_rsp_out;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fsm_arbiter #(.HOLD(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .j0(j0), .k0(k0), .j1(j1), .k1(k1),
        .fsm_out(fsm_out),
        .gnt0(gnt0), .gnt1(gnt1), .fsm_j(fsm_j), .fsm_k(fsm_k),
        .done0(done0), .done1(done1), .rsp_out(rsp_out)
    );

    fsm_arbiter #(.HOLD(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .req0(b_req0), .req1(b_req1), .j0(b_j0), .k0(b_k0), .j1(b_j1), .k1(b_k1),
        .fsm_out(b_fsm_out),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .fsm_j(b_fsm_j), .fsm_k(b_fsm_k),
        .done0(b_done0), .done1(b_done1), .rsp_out(b_rsp_out)
    );

    // Output vectors ordered {gnt0, gnt1, fsm_j, fsm_k, done0, done1}
    logic [5:0] v4, v1;
    assign v4 = {gnt0, gnt1, fsm_j, fsm_k, done0, done1};
    assign v1 = {b_gnt0, b_gnt1, b_fsm_j, b_fsm_k, b_done0, b_done1};

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
        $display("check %-14s observed %b expected %b", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       rr;
        logic       w;
        logic [5:0] g_exp;
`ifdef ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        reset = 1'b0;
        {req0, req1, j0, k0, j1, k1, fsm_out} = '0;
        {b_req0, b_req1, b_j0, b_k0, b_j1, b_k1, b_fsm_out} = '0;
        cyc();
        cyc();
        chk("reset_out", v4, 6'b000000);
        chk("reset_rsp", {5'd0, rsp_out}, 6'd1 & 6'd0);
        reset = 1'b1;

        // Single requester 0 held: four grant cycles, release, idle, grant again.
        req0 = 1'b1; j0 = 1'b1; k0 = 1'b0; j1 = 1'b0; k1 = 1'b1; fsm_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("hold_grant", v4, 6'b101000);
        end
        cyc();
        chk("hold_release", v4, 6'b000010);
        chk("hold_rsp", {5'd0, rsp_out}, 6'd1);
        cyc();
        chk("hold_idle", v4, 6'b000000);
        cyc();
        chk("regrant", v4, 6'b101000);
        // req dropped during the first grant cycle still gets that cycle.
        req0 = 1'b0; fsm_out = 1'b0;
        cyc();
        chk("early_release", v4, 6'b000010);
        chk("early_rsp", {5'd0, rsp_out}, 6'd0);
        cyc();
        chk("early_idle", v4, 6'b000000);

        // Ties after reset: requester 0 first, then alternate only with ROUND_ROBIN_EN.
        reset = 1'b0;
        cyc();
        req0 = 1'b1; req1 = 1'b1; j0 = 1'b0; k0 = 1'b1; j1 = 1'b1; k1 = 1'b0;
        reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            w     = rr ? r[0] : 1'b0;
            g_exp = w ? 6'b011000 : 6'b100100;
            for (int i = 0; i < 4; i++) begin
                cyc();
                chk(w ? "tie_gnt1" : "tie_gnt0", v4, g_exp);
            end
            cyc();
            chk("tie_release", v4, w ? 6'b000001 : 6'b000010);
            cyc();
            chk("tie_idle", v4, 6'b000000);
        end

        // Requester 1 drops after two grant cycles while requester 0 waits.
        req0 = 1'b0; req1 = 1'b1; fsm_out = 1'b1;
        cyc();
        chk("r1_grant_a", v4, 6'b011000);
        cyc();
        chk("r1_grant_b", v4, 6'b011000);
        req1 = 1'b0; req0 = 1'b1;
        cyc();
        chk("r1_release", v4, 6'b000001);
        chk("r1_rsp", {5'd0, rsp_out}, 6'd1);
        cyc();
        chk("r1_idle", v4, 6'b000000);
        cyc();
        chk("r0_pending", v4, 6'b100100);

        // Asynchronous reset in the third grant cycle.
        cyc();
        cyc();
        chk("grant3", v4, 6'b100100);
        #2 reset = 1'b0;
        #1;
        chk("async_rst", v4, 6'b000000);
        chk("async_rsp", {5'd0, rsp_out}, 6'd0);
        req0 = 1'b1; req1 = 1'b1;
        cyc();
        chk("rst_held", v4, 6'b000000);
        reset = 1'b1;
        cyc();
        chk("post_rst_gnt0", v4, 6'b100100);

        // HOLD=1: grant, release, idle repeating.
        req0 = 1'b0; req1 = 1'b0;
        b_req0 = 1'b1; b_j0 = 1'b1; b_k0 = 1'b1; b_j1 = 1'b0; b_k1 = 1'b0; b_fsm_out = 1'b1;
        for (int r = 0; r < 3; r++) begin
            cyc();
            chk("h1_grant", v1, 6'b101100);
            cyc();
            chk("h1_release", v1, 6'b000010);
            chk("h1_rsp", {5'd0, b_rsp_out}, 6'd1);
            cyc();
            chk("h1_idle", v1, 6'b000000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
